apb_mem_slave: RTL and testbench
================================

Name: apb_mem_slave

Overview:
- Parametrised APB3 memory-mapped slave: on-chip register/memory array with byte strobes, configurable wait states and error signalling.
- Successor to the fixed 8-bit-address / 32-bit-data slave.
- Adds out-of-range and write-protect detection via pslverr, plus correct pready handshaking.
- Sits behind the APB bridge as a scratchpad/config store.

Parameters:
- ADDR_W, 8: paddr width; paddr is a word index.
- DATA_W, 32: data width; must be a multiple of 8.
- DEPTH, 256: implemented words; valid indices 0..DEPTH-1; DEPTH <= 2^ADDR_W.
- WP_BASE, 240: first write-protected index; indices WP_BASE..DEPTH-1 are read-only. WP_BASE >= DEPTH disables protection.
- WAIT_STATES, 0: extra access-phase cycles before pready; range 0..15.

Ports:
- pclk, in, 1: clock.
- presetn, in, 1: reset, asynchronous, active-low.
- paddr, in, ADDR_W: word address.
- psel, in, 1: slave select.
- penable, in, 1: access phase.
- pwrite, in, 1: 1 = write, 0 = read.
- pwdata, in, DATA_W: write data.
- pstrb, in, DATA_W/8: byte write enables; bit i enables pwdata[8i+7:8i].
- prdata, out, DATA_W: read data, registered.
- pready, out, 1: transfer complete, registered.
- pslverr, out, 1: transfer error, registered, qualified by pready.

Behaviour:
- Reset, presetn low, asynchronous: prdata=0, pready=0, pslverr=0, state=IDLE, wait counter=0. Memory contents are not reset. Reset mid-transfer drops any pending write.
- FSM states:
  - IDLE: sample psel=1 & penable=0 -> ACCESS. Load cnt=WAIT_STATES. pready <= (WAIT_STATES==0). penable without psel is ignored.
  - ACCESS, pready=0: if psel=1 & penable=1, cnt decrements and pready <= (cnt==1). If psel=0, abort: -> IDLE, no write, outputs cleared.
  - ACCESS, pready=1: this is the completion edge. Write commits here if permitted. Then pready<=0, pslverr<=0, prdata<=0, -> IDLE.
- Latency: access phase lasts WAIT_STATES+1 cycles. With WAIT_STATES=0, each transfer takes 2 cycles (setup + access). Back-to-back transfers work because IDLE samples the next setup in the cycle after completion.
- prdata and pslverr load on the same edge that sets pready=1.
- Reads: prdata = mem[paddr] if paddr < DEPTH; otherwise prdata = 0 and pslverr = 1.
- Writes:
  - paddr >= DEPTH: pslverr=1, no write.
  - WP_BASE <= paddr < DEPTH: pslverr=1, memory unchanged.
  - Otherwise: only bytes with pstrb[i]=1 update. pstrb=0 is a legal no-op with pslverr=0.
- Read data reflects memory before a write in the same transfer. A read issued immediately after a write to the same address returns the new data.
- paddr, pwrite, pwdata and pstrb are sampled at the completion edge; the master holds them stable per APB.
- prdata is 0 whenever pready=0.

Test Plan:
- Reset, write 0xDEADBEEF to 0x10 with pstrb=0xF, read 0x10 -> prdata=0xDEADBEEF, pslverr=0. With WAIT_STATES=0, pready is high in the second cycle of each transfer.
- Write 0x11223344 to 0x20, then write 0xAABBCCDD with pstrb=0b0101, read -> 0x11BB33DD.
- Write 0xFFFFFFFF to WP_BASE=240 -> pslverr=1 with pready. A subsequent read of 240 returns prior contents, with pslverr=0.
- With DEPTH=128, ADDR_W=8, read 0xC8 -> pslverr=1, prdata=0. A write to 0xC8 -> pslverr=1, no memory index is modified.
- With WAIT_STATES=3, for a read: pready stays low for 3 access cycles and rises on the 4th. Repeat the same check for a write. Drop psel during a wait -> transfer aborted, memory unchanged, pready never asserts.
- Assert presetn low during the access phase of a write to 0x05 -> outputs go to 0 immediately. After release, a read of 0x05 returns its old value; a following back-to-back write then read completes normally.

Source files
------------

// File: rtl/apb_mem_slave.sv
// APB3 memory-mapped slave: word-addressed RAM with byte strobes, configurable
// wait states, and pslverr on out-of-range or write-protected accesses.
module apb_mem_slave #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WP_BASE     = 240,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                pclk,
    input  logic                presetn,
    input  logic [ADDR_W-1:0]   paddr,
    input  logic                psel,
    input  logic                penable,
    input  logic                pwrite,
    input  logic [DATA_W-1:0]   pwdata,
    input  logic [DATA_W/8-1:0] pstrb,
    output logic [DATA_W-1:0]   prdata,
    output logic                pready,
    output logic                pslverr
);

    localparam int unsigned NB      = DATA_W / 8;
    localparam int unsigned IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned WP_EFF  = (WP_BASE < DEPTH) ? WP_BASE : DEPTH;
    localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] WP_L      = (ADDR_W + 1)'(WP_EFF);
    localparam logic [CNT_W-1:0] WS_L     = CNT_W'(WAIT_STATES);
    localparam logic            NO_WAIT   = (WAIT_STATES == 0);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pready_d, pslverr_d;
    logic [DATA_W-1:0] prdata_d;

    logic              in_range_c, wp_hit_c, err_c, mem_we_c;
    logic [IDX_W-1:0]  idx_c;
    logic [DATA_W-1:0] rd_data_c;
    logic              setup_c;

    // Address decode and completion response for the current bus request
    always_comb begin
        in_range_c = ({1'b0, paddr} < DEPTH_L);
        wp_hit_c   = in_range_c && ({1'b0, paddr} >= WP_L);
        idx_c      = IDX_W'(paddr);
        err_c      = pwrite ? (!in_range_c || wp_hit_c) : !in_range_c;
        rd_data_c  = '0;
        if (!pwrite && in_range_c) begin
            rd_data_c = mem[idx_c];
        end
        setup_c    = psel && !penable;
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pready  <= 1'b0;
            pslverr <= 1'b0;
            prdata  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pready  <= pready_d;
            pslverr <= pslverr_d;
            prdata  <= prdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (setup_c) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (pready || !psel) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Response registers and write strobe; pready/prdata/pslverr rise together
    always_comb begin
        cnt_d     = cnt_q;
        pready_d  = pready;
        pslverr_d = pslverr;
        prdata_d  = prdata;
        mem_we_c  = 1'b0;
        case (state_q)
            IDLE: begin
                pready_d  = 1'b0;
                pslverr_d = 1'b0;
                prdata_d  = '0;
                if (setup_c) begin
                    cnt_d    = WS_L;
                    pready_d = NO_WAIT;
                    if (NO_WAIT) begin
                        pslverr_d = err_c;
                        prdata_d  = rd_data_c;
                    end
                end
            end
            ACCESS: begin
                if (pready) begin
                    mem_we_c  = pwrite && in_range_c && !wp_hit_c;
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                    prdata_d  = '0;
                end else if (!psel) begin
                    cnt_d     = '0;
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                    prdata_d  = '0;
                end else if (penable) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        pready_d  = 1'b1;
                        pslverr_d = err_c;
                        prdata_d  = rd_data_c;
                    end
                end
            end
            default: begin
                cnt_d     = '0;
                pready_d  = 1'b0;
                pslverr_d = 1'b0;
                prdata_d  = '0;
            end
        endcase
    end

    // Storage is intentionally not reset
    always_ff @(posedge pclk) begin
        if (mem_we_c) begin
            for (int b = 0; b < NB; b++) begin
                if (pstrb[b]) begin
                    mem[idx_c][b*8 +: 8] <= pwdata[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_mem_slave.sv
// Directed bench for apb_mem_slave: one default instance and one with
// DEPTH=128 / WAIT_STATES=3 sharing the address/data bus.
module tb_apb_mem_slave;

    logic        pclk = 1'b0;
    logic        presetn;
    logic [7:0]  paddr;
    logic        psel_a, psel_b, penable, pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata_a, prdata_b;
    logic        pready_a, pready_b, pslverr_a, pslverr_b;

    int total = 0;
    int bad   = 0;

    always #5 pclk = ~pclk;

    apb_mem_slave dut_a (
        .pclk(pclk), .presetn(presetn), .paddr(paddr), .psel(psel_a),
        .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata_a), .pready(pready_a), .pslverr(pslverr_a)
    );

    apb_mem_slave #(.DEPTH(128), .WAIT_STATES(3)) dut_b (
        .pclk(pclk), .presetn(presetn), .paddr(paddr), .psel(psel_b),
        .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata_b), .pready(pready_b), .pslverr(pslverr_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic rdy(input int d);
        return (d == 0) ? pready_a : pready_b;
    endfunction

    // One APB transfer; entered and left at 1 time unit after a rising edge
    task automatic xfer(input int d, input logic wr, input logic [7:0] a,
                        input logic [31:0] wd, input logic [3:0] st,
                        output logic [31:0] rd, output logic err, output int waits);
        paddr   = a;
        pwrite  = wr;
        pwdata  = wd;
        pstrb   = st;
        penable = 1'b0;
        psel_a  = (d == 0);
        psel_b  = (d != 0);
        @(posedge pclk); #1;
        penable = 1'b1;
        waits   = 0;
        while (!rdy(d) && waits < 40) begin
            @(posedge pclk); #1;
            waits++;
        end
        if (waits >= 40) chk("timeout", 32'd1, 32'd0);
        rd  = (d == 0) ? prdata_a : prdata_b;
        err = (d == 0) ? pslverr_a : pslverr_b;
        @(posedge pclk); #1;
        psel_a  = 1'b0;
        psel_b  = 1'b0;
        penable = 1'b0;
    endtask

    logic [31:0] rd, prior;
    logic        err;
    int          w;
    logic        seen;

    initial begin
        presetn = 1'b0;
        paddr = '0; psel_a = 0; psel_b = 0; penable = 0; pwrite = 0;
        pwdata = '0; pstrb = '0;
        #1;
        chk("rst_pready", 32'(pready_a), 32'd0);
        chk("rst_prdata", prdata_a, 32'd0);
        chk("rst_pslverr", 32'(pslverr_a), 32'd0);
        chk("rst_pready_b", 32'(pready_b), 32'd0);
        @(posedge pclk); #1;
        presetn = 1'b1;
        @(posedge pclk); #1;

        xfer(0, 1, 8'h10, 32'hDEADBEEF, 4'hF, rd, err, w);
        chk("wr10_err", 32'(err), 32'd0);
        chk("wr10_waits", 32'(w), 32'd0);
        xfer(0, 0, 8'h10, 32'h0, 4'h0, rd, err, w);
        chk("rd10_data", rd, 32'hDEADBEEF);
        chk("rd10_err", 32'(err), 32'd0);
        chk("rd10_waits", 32'(w), 32'd0);
        chk("prdata_idle", prdata_a, 32'd0);

        xfer(0, 1, 8'h20, 32'h11223344, 4'hF, rd, err, w);
        xfer(0, 1, 8'h20, 32'hAABBCCDD, 4'b0101, rd, err, w);
        chk("strb_err", 32'(err), 32'd0);
        xfer(0, 0, 8'h20, 32'h0, 4'h0, rd, err, w);
        chk("strb_data", rd, 32'h11BB33DD);

        xfer(0, 1, 8'h30, 32'hCAFEF00D, 4'hF, rd, err, w);
        xfer(0, 1, 8'h30, 32'h00000000, 4'h0, rd, err, w);
        chk("strb0_err", 32'(err), 32'd0);
        xfer(0, 0, 8'h30, 32'h0, 4'h0, rd, err, w);
        chk("strb0_data", rd, 32'hCAFEF00D);

        xfer(0, 1, 8'd239, 32'h5A5A0001, 4'hF, rd, err, w);
        chk("wr239_err", 32'(err), 32'd0);
        xfer(0, 0, 8'd239, 32'h0, 4'h0, rd, err, w);
        chk("rd239_data", rd, 32'h5A5A0001);
        xfer(0, 0, 8'd240, 32'h0, 4'h0, rd, err, w);
        prior = rd;
        xfer(0, 1, 8'd240, 32'hFFFFFFFF, 4'hF, rd, err, w);
        chk("wp240_err", 32'(err), 32'd1);
        xfer(0, 1, 8'd255, 32'hFFFFFFFF, 4'hF, rd, err, w);
        chk("wp255_err", 32'(err), 32'd1);
        xfer(0, 0, 8'd240, 32'h0, 4'h0, rd, err, w);
        chk("wp240_rd_err", 32'(err), 32'd0);
        chk("wp240_rd_data", rd, prior);

        xfer(1, 1, 8'h48, 32'h48484848, 4'hF, rd, err, w);
        chk("b_wr_waits", 32'(w), 32'd3);
        chk("b_wr_err", 32'(err), 32'd0);
        xfer(1, 0, 8'h48, 32'h0, 4'h0, rd, err, w);
        chk("b_rd_waits", 32'(w), 32'd3);
        chk("b_rd_data", rd, 32'h48484848);
        xfer(1, 0, 8'hC8, 32'h0, 4'h0, rd, err, w);
        chk("oor_rd_err", 32'(err), 32'd1);
        chk("oor_rd_data", rd, 32'd0);
        xfer(1, 1, 8'hC8, 32'h0BADF00D, 4'hF, rd, err, w);
        chk("oor_wr_err", 32'(err), 32'd1);
        xfer(1, 0, 8'h48, 32'h0, 4'h0, rd, err, w);
        chk("oor_alias", rd, 32'h48484848);

        xfer(1, 1, 8'h10, 32'h12345678, 4'hF, rd, err, w);
        paddr = 8'h10; pwrite = 1; pwdata = 32'h0; pstrb = 4'hF;
        psel_b = 1; penable = 0;
        @(posedge pclk); #1;
        penable = 1;
        @(posedge pclk); #1;
        psel_b = 0; penable = 0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge pclk); #1;
            seen = seen | pready_b;
        end
        chk("abort_pready", 32'(seen), 32'd0);
        xfer(1, 0, 8'h10, 32'h0, 4'h0, rd, err, w);
        chk("abort_data", rd, 32'h12345678);

        xfer(0, 1, 8'h05, 32'h0505A5A5, 4'hF, rd, err, w);
        paddr = 8'h05; pwrite = 1; pwdata = 32'hFFFF0000; pstrb = 4'hF;
        psel_a = 1; penable = 0;
        @(posedge pclk); #1;
        penable = 1;
        chk("pre_rst_pready", 32'(pready_a), 32'd1);
        presetn = 1'b0;
        #1;
        chk("midrst_pready", 32'(pready_a), 32'd0);
        chk("midrst_pslverr", 32'(pslverr_a), 32'd0);
        chk("midrst_prdata", prdata_a, 32'd0);
        @(posedge pclk); #1;
        psel_a = 0; penable = 0;
        presetn = 1'b1;
        @(posedge pclk); #1;
        xfer(0, 0, 8'h05, 32'h0, 4'h0, rd, err, w);
        chk("rst_keep_data", rd, 32'h0505A5A5);
        xfer(0, 1, 8'h05, 32'h01020304, 4'hF, rd, err, w);
        xfer(0, 0, 8'h05, 32'h0, 4'h0, rd, err, w);
        chk("b2b_data", rd, 32'h01020304);
        chk("b2b_waits", 32'(w), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
